// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin arbiter that shares one fifo_async write port among NumReq
// requesters in the write clock domain. A grant covers a whole burst: the
// winner keeps the port until it presents a last beat or MaxBurst beats are
// accepted. The arbitration decision is registered. Data and handshakes pass
// through combinationally from the granted requester to the FIFO.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no owner; search from rr_ptr and register the winner for next cycle
// BURST | grant g owns the FIFO port; beats flow whenever FIFO not full

module fifo_wr_arbiter #(
   parameter int NumReq   = 4,
   parameter int Width    = 8,
   parameter int MaxBurst = 16
) (
   input  logic                      i_clk,
   input  logic                      i_rstn,
   input  logic [NumReq-1:0]         i_req_valid,
   input  logic [NumReq*Width-1:0]   i_req_data,
   input  logic [NumReq-1:0]         i_req_last,
   output logic [NumReq-1:0]         o_req_ready,
   output logic                      o_fifo_wr_en,
   output logic [Width-1:0]          o_fifo_wr_data,
   input  logic                      i_fifo_full,
   output logic [NumReq-1:0]         o_grant,
   output logic                      o_busy
);

   localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
   localparam int CntW = $clog2(MaxBurst + 1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   state_t            state, state_n;
   logic [IdxW-1:0]   rr_ptr, rr_ptr_n;
   logic [IdxW-1:0]   gidx, gidx_n;
   logic [NumReq-1:0] grant, grant_n;
   logic [CntW-1:0]   beat_cnt, beat_cnt_n;

   logic              pick_found;
   logic [IdxW-1:0]   pick_idx;
   logic              accept;
   logic              burst_end;

   // Rotating priority search: first valid requester at or after rr_ptr.
   always_comb begin
      int j;
      pick_found = 1'b0;
      pick_idx   = '0;
      j          = 0;
      for (int k = 0; k < NumReq; k++) begin
         j = int'(rr_ptr) + k;
         if (j >= NumReq) j = j - NumReq;
         if (!pick_found && i_req_valid[j]) begin
            pick_found = 1'b1;
            pick_idx   = IdxW'(j);
         end
      end
   end

   // Next-state logic and FIFO-side outputs.
   always_comb begin
      state_n        = state;
      rr_ptr_n       = rr_ptr;
      gidx_n         = gidx;
      grant_n        = grant;
      beat_cnt_n     = beat_cnt;
      o_req_ready    = '0;
      o_fifo_wr_en   = 1'b0;
      o_fifo_wr_data = '0;
      o_busy         = 1'b0;
      accept         = 1'b0;
      burst_end      = 1'b0;

      case (state)
         IDLE: begin
            if (pick_found) begin
               state_n    = BURST;
               gidx_n     = pick_idx;
               grant_n    = {{(NumReq-1){1'b0}}, 1'b1} << pick_idx;
               beat_cnt_n = '0;
            end
         end
         BURST: begin
            o_busy         = 1'b1;
            o_fifo_wr_data = i_req_data[gidx*Width +: Width];
            if (!i_fifo_full) o_req_ready = grant;
            accept         = i_req_valid[gidx] & ~i_fifo_full;
            o_fifo_wr_en   = accept;
            // Last flag and the beat cap can coincide; either ends the burst once.
            burst_end      = accept &
                             (i_req_last[gidx] | (beat_cnt == CntW'(MaxBurst - 1)));
            if (accept) beat_cnt_n = beat_cnt + 1'b1;
            if (burst_end) begin
               state_n    = IDLE;
               grant_n    = '0;
               beat_cnt_n = '0;
               rr_ptr_n   = (gidx == IdxW'(NumReq - 1)) ? '0 : gidx + 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
            grant_n = '0;
         end
      endcase
   end

   // State, pointer, grant and beat counter registers.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         gidx     <= '0;
         grant    <= '0;
         beat_cnt <= '0;
      end else begin
         state    <= state_n;
         rr_ptr   <= rr_ptr_n;
         gidx     <= gidx_n;
         grant    <= grant_n;
         beat_cnt <= beat_cnt_n;
      end
   end

   assign o_grant = grant;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: vector table, directed multi-cycle sequences and
// a randomized run against a behavioural model of the arbitration rules.

module tb_fifo_wr_arbiter;

   localparam int NR = 4;
   localparam int W  = 8;
   localparam int MB = 16;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [NR-1:0]   req_valid = '0;
   logic [NR*W-1:0] req_data = '0;
   logic [NR-1:0]   req_last = '0;
   logic [NR-1:0]   req_ready;
   logic            fifo_wr_en;
   logic [W-1:0]    fifo_wr_data;
   logic            fifo_full = 1'b0;
   logic [NR-1:0]   grant;
   logic            busy;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   fifo_wr_arbiter #(.NumReq(NR), .Width(W), .MaxBurst(MB)) dut (
      .i_clk          (clk),
      .i_rstn         (rst_n),
      .i_req_valid    (req_valid),
      .i_req_data     (req_data),
      .i_req_last     (req_last),
      .o_req_ready    (req_ready),
      .o_fifo_wr_en   (fifo_wr_en),
      .o_fifo_wr_data (fifo_wr_data),
      .i_fifo_full    (fifo_full),
      .o_grant        (grant),
      .o_busy         (busy)
   );

   typedef struct packed {
      logic [NR-1:0] valid;
      logic [NR-1:0] last;
      logic          full;
      logic [NR-1:0] grant;
      logic [NR-1:0] ready;
      logic          wr_en;
      logic [W-1:0]  data;
   } vec_t;

   vec_t tbl [17];

   function automatic vec_t mk(logic [3:0] l, logic f, logic [3:0] g, logic [3:0] r,
                               logic we, logic [7:0] d);
      vec_t v;
      v.valid = 4'hF; v.last = l; v.full = f; v.grant = g;
      v.ready = r; v.wr_en = we; v.data = d;
      return v;
   endfunction

   function automatic logic [63:0] outs();
      return 64'({req_ready, fifo_wr_en, fifo_wr_data, grant, busy});
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      rst_n     = 1'b0;
      req_valid = '1;
      req_last  = '0;
      req_data  = '0;
      fifo_full = 1'b0;
      #1;
      chk("reset_outputs_zero", outs(), 64'd0);
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // behavioural model state
   int            m_owner;
   int            m_ptr;
   int            m_cnt;
   logic [NR-1:0] pv;
   logic [NR-1:0] pl;
   logic [W-1:0]  pd [NR];

   initial begin
      int acc, cur, err, n3, stall, n1;
      logic seen, done;
      logic [NR-1:0] prevg;
      int blen[$];

      // ---------------- test 1: reset and first grant
      @(posedge clk); #1;
      reset_dut();
      req_valid = '1;
      @(negedge clk);
      chk("t1_idle_after_release", outs(), 64'd0);
      tick();
      @(negedge clk);
      chk("t1_first_grant_req0", 64'(grant), 64'(4'b0001));
      tick();

      // ---------------- test 2: round-robin table
      tbl[0]  = mk(4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h00);
      tbl[1]  = mk(4'b0000, 0, 4'b0001, 4'b0001, 1, 8'hA0);
      tbl[2]  = mk(4'b0001, 0, 4'b0001, 4'b0001, 1, 8'hA0);
      tbl[3]  = mk(4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h00);
      tbl[4]  = mk(4'b0000, 0, 4'b0010, 4'b0010, 1, 8'hA1);
      tbl[5]  = mk(4'b0010, 0, 4'b0010, 4'b0010, 1, 8'hA1);
      tbl[6]  = mk(4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h00);
      tbl[7]  = mk(4'b0000, 0, 4'b0100, 4'b0100, 1, 8'hA2);
      tbl[8]  = mk(4'b0100, 0, 4'b0100, 4'b0100, 1, 8'hA2);
      tbl[9]  = mk(4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h00);
      tbl[10] = mk(4'b0000, 0, 4'b1000, 4'b1000, 1, 8'hA3);
      tbl[11] = mk(4'b1000, 0, 4'b1000, 4'b1000, 1, 8'hA3);
      tbl[12] = mk(4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h00);
      tbl[13] = mk(4'b0000, 0, 4'b0001, 4'b0001, 1, 8'hA0);
      tbl[14] = mk(4'b0001, 1, 4'b0001, 4'b0000, 0, 8'hA0);
      tbl[15] = mk(4'b0001, 0, 4'b0001, 4'b0001, 1, 8'hA0);
      tbl[16] = mk(4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h00);

      reset_dut();
      req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      for (int i = 0; i < 17; i++) begin
         req_valid = tbl[i].valid;
         req_last  = tbl[i].last;
         fifo_full = tbl[i].full;
         @(negedge clk);
         chk($sformatf("t2_vec%0d", i), outs(),
             64'({tbl[i].ready, tbl[i].wr_en, tbl[i].data, tbl[i].grant, |tbl[i].grant}));
         tick();
      end

      // ---------------- test 3: MaxBurst cap on a 40-beat stream from req1
      reset_dut();
      acc = 0; cur = 0; err = 0; n3 = 0; prevg = '0; blen.delete();
      for (int c = 0; c < 300 && acc < 40; c++) begin
         req_valid = 4'b1010;
         req_last  = 4'b1000;
         fifo_full = 1'b0;
         req_data[15:8]  = 8'(acc);
         req_data[31:24] = 8'hEE;
         @(negedge clk);
         if (fifo_wr_en && grant == 4'b0010) begin
            if (fifo_wr_data !== 8'(acc)) err++;
            acc++; cur++;
         end
         if (fifo_wr_en && grant == 4'b1000) n3++;
         if (grant != 4'b0010 && prevg == 4'b0010) begin
            blen.push_back(cur);
            cur = 0;
         end
         prevg = grant;
         tick();
      end
      req_valid = 4'b1000;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("t3_gap_holds_grant", 64'({grant, fifo_wr_en, busy}), 64'({4'b0010, 1'b0, 1'b1}));
         tick();
      end
      chk("t3_beats_accepted", 64'(acc), 64'd40);
      chk("t3_closed_bursts", 64'(blen.size()), 64'd2);
      chk("t3_burst0_len", 64'(blen.size() > 0 ? blen[0] : -1), 64'd16);
      chk("t3_burst1_len", 64'(blen.size() > 1 ? blen[1] : -1), 64'd16);
      chk("t3_open_burst_len", 64'(cur), 64'd8);
      chk("t3_data_order_errors", 64'(err), 64'd0);
      chk("t3_req3_served_between", 64'(n3), 64'd2);

      // ---------------- test 4: full stall mid-burst
      reset_dut();
      acc = 0; stall = 0; err = 0; seen = 0; done = 0;
      for (int c = 0; c < 60 && !done; c++) begin
         fifo_full      = (acc == 2 && stall < 5);
         req_valid      = 4'b0001;
         req_data[7:0]  = 8'(acc);
         req_last       = (acc == 5) ? 4'b0001 : 4'b0000;
         @(negedge clk);
         if (fifo_full) begin
            chk("t4_stall", 64'({req_ready, fifo_wr_en, grant}), 64'({4'b0000, 1'b0, 4'b0001}));
            stall++;
         end
         if (fifo_wr_en) begin
            if (fifo_wr_data !== 8'(acc)) err++;
            acc++;
         end
         if (grant == 4'b0001) seen = 1'b1;
         else if (seen) done = 1'b1;
         tick();
      end
      fifo_full = 1'b0;
      chk("t4_beats_written", 64'(acc), 64'd6);
      chk("t4_stall_cycles", 64'(stall), 64'd5);
      chk("t4_data_errors", 64'(err), 64'd0);

      // ---------------- test 5: last coincides with cap, then req3 next
      reset_dut();
      acc = 0; seen = 0; done = 0;
      for (int c = 0; c < 80 && !done; c++) begin
         req_valid        = seen ? 4'b1101 : 4'b0100;
         req_last         = {1'b1, (acc == 15), 1'b0, 1'b1};
         req_data[23:16]  = 8'(acc);
         @(negedge clk);
         if (grant == 4'b0100) begin
            seen = 1'b1;
            if (fifo_wr_en) acc++;
         end else if (seen) done = 1'b1;
         tick();
      end
      @(negedge clk);
      chk("t5_req2_burst_len", 64'(acc), 64'd16);
      chk("t5_next_grant_req3", 64'(grant), 64'(4'b1000));
      tick();

      // ---------------- test 6: reset mid-burst
      reset_dut();
      acc = 0; n1 = 0;
      for (int c = 0; c < 20 && acc < 3; c++) begin
         req_valid     = (n1 == 0) ? 4'b0010 : 4'b0001;
         req_last      = (n1 == 0) ? 4'b0010 : 4'b0000;
         req_data[7:0] = 8'(acc);
         @(negedge clk);
         if (fifo_wr_en && grant == 4'b0010) n1++;
         if (fifo_wr_en && grant == 4'b0001) acc++;
         tick();
      end
      chk("t6_busy_before_reset", 64'({grant, busy}), 64'({4'b0001, 1'b1}));
      chk("t6_fifo_holds_3", 64'(acc), 64'd3);
      req_valid = '1;
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_outputs_zero_at_once", outs(), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("t6_idle_after_release", outs(), 64'd0);
      tick();
      @(negedge clk);
      chk("t6_rearb_from_req0", 64'(grant), 64'(4'b0001));
      tick();

      // ---------------- randomized run against the behavioural model
      reset_dut();
      m_owner = -1; m_ptr = 0; m_cnt = 0;
      pv = '0; pl = '0;
      for (int r = 0; r < NR; r++) pd[r] = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         logic          e_busy, e_wr, found;
         logic [NR-1:0] e_grant, e_ready;
         logic [W-1:0]  e_data;
         for (int r = 0; r < NR; r++) begin
            if (!pv[r] && $urandom_range(0, 2) == 0) begin
               pv[r] = 1'b1;
               pd[r] = W'($urandom);
               pl[r] = ($urandom_range(0, 7) == 0);
            end
            req_data[r*W +: W] = pd[r];
         end
         req_valid = pv;
         req_last  = pl;
         fifo_full = ($urandom_range(0, 4) == 0);
         @(negedge clk);
         e_busy  = (m_owner >= 0);
         e_grant = e_busy ? (4'b0001 << m_owner) : 4'b0000;
         e_ready = (e_busy && !fifo_full) ? e_grant : 4'b0000;
         e_wr    = e_busy && pv[m_owner] && !fifo_full;
         e_data  = e_busy ? pd[m_owner] : '0;
         chk($sformatf("rand_cyc%0d", cyc), outs(),
             64'({e_ready, e_wr, e_data, e_grant, e_busy}));
         if (!e_busy) begin
            found = 1'b0;
            for (int k = 0; k < NR; k++) begin
               if (!found && pv[(m_ptr + k) % NR]) begin
                  found   = 1'b1;
                  m_owner = (m_ptr + k) % NR;
                  m_cnt   = 0;
               end
            end
         end else if (e_wr) begin
            m_cnt++;
            pv[m_owner] = 1'b0;
            if (pl[m_owner] || m_cnt == MB) begin
               m_ptr   = (m_owner + 1) % NR;
               m_owner = -1;
            end
         end
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
